rbz_spi_cmd_master: RTL and testbench

RBZ_SPI_CMD_MASTER -- requirements
Module: rbz_spi_cmd_master

---
 rtl/rbz_spi_cmd_master_if.sv | 12 +
 rtl/rbz_spi_cmd_master.sv | 143 ++++++++++++++
 tb/tb_rbz_spi_cmd_master.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rbz_spi_cmd_master_if.sv
// rtl/rbz_spi_cmd_master_if.sv - command offer handshake bundle for rbz_spi_cmd_master
// Signal names keep the DUT-relative i_/o_ direction prefixes.
interface rbz_spi_cmd_master_if;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_cmd;
  logic [23:0] i_data;
  logic [4:0]  i_nbits;

  modport master (output i_valid, i_cmd, i_data, i_nbits, input o_ready);
  modport slave  (input i_valid, i_cmd, i_data, i_nbits, output o_ready);
endinterface

// File: rtl/rbz_spi_cmd_master.sv
// rtl/rbz_spi_cmd_master.sv - SPI mode-0 command master for raybox-zero reg/vec slaves
// One-entry holding register feeds a 4-bit opcode plus up to 24 payload bits, MSB first.
module rbz_spi_cmd_master #(
  parameter int CLK_DIV = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  rbz_spi_cmd_master_if.slave        cmd_if,
  output logic                       o_csb,
  output logic                       o_sclk,
  output logic                       o_mosi,
  output logic                       o_busy,
  output logic                       o_done
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;

  localparam logic [7:0] C_RELOAD = 8'(CLK_DIV - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [26:0] r_sr;
  logic [4:0]  r_bits;
  logic        r_hold_vld;
  logic [3:0]  r_hold_cmd;
  logic [23:0] r_hold_data;
  logic [4:0]  r_hold_nbits;
  logic        r_csb;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_done;

  logic        w_accept;
  logic        w_cnt_zero;
  logic [4:0]  w_nbits_clamped;

  assign w_accept        = cmd_if.i_valid && !r_hold_vld;
  assign w_cnt_zero      = (r_cnt == 8'd0);
  assign w_nbits_clamped = (cmd_if.i_nbits > 5'd24) ? 5'd24 : cmd_if.i_nbits;

  assign cmd_if.o_ready = !r_hold_vld;
  assign o_csb          = r_csb;
  assign o_sclk         = r_sclk;
  assign o_mosi         = r_mosi;
  assign o_done         = r_done;
  assign o_busy         = (r_state != IDLE);

  // r_mosi holds the bit on the wire; r_sr holds the bits still to follow it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= 8'd0;
      r_sr         <= 27'd0;
      r_bits       <= 5'd0;
      r_hold_vld   <= 1'b0;
      r_hold_cmd   <= 4'd0;
      r_hold_data  <= 24'd0;
      r_hold_nbits <= 5'd0;
      r_csb        <= 1'b1;
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        r_hold_vld   <= 1'b1;
        r_hold_cmd   <= cmd_if.i_cmd;
        r_hold_data  <= cmd_if.i_data;
        r_hold_nbits <= w_nbits_clamped;
      end

      case (r_state)
        IDLE: begin
          if (r_hold_vld) begin
            r_hold_vld <= 1'b0;
            r_sr       <= {r_hold_cmd[2:0], r_hold_data};
            r_bits     <= r_hold_nbits + 5'd4;
            r_csb      <= 1'b0;
            r_mosi     <= r_hold_cmd[3];
            r_sclk     <= 1'b0;
            r_cnt      <= C_RELOAD;
            r_state    <= SETUP;
          end
        end

        SETUP: begin
          if (w_cnt_zero) begin
            r_sclk  <= 1'b1;
            r_cnt   <= C_RELOAD;
            r_state <= SHIFT_HI;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        SHIFT_HI: begin
          if (w_cnt_zero) begin
            r_sclk  <= 1'b0;
            r_bits  <= r_bits - 5'd1;
            r_cnt   <= C_RELOAD;
            r_state <= SHIFT_LO;
            if (r_bits > 5'd1) begin
              r_mosi <= r_sr[26];
              r_sr   <= {r_sr[25:0], 1'b0};
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        SHIFT_LO: begin
          if (w_cnt_zero) begin
            r_cnt <= C_RELOAD;
            if (r_bits != 5'd0) begin
              r_sclk  <= 1'b1;
              r_state <= SHIFT_HI;
            end else begin
              r_csb   <= 1'b1;
              r_mosi  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= GAP;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        GAP: begin
          if (w_cnt_zero) begin
            r_cnt   <= C_RELOAD;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rbz_spi_cmd_master.sv
// tb/tb_rbz_spi_cmd_master.sv - self-checking bench for rbz_spi_cmd_master
// Four instances cover CLK_DIV 1..4; a wire-level monitor feeds a frame-level reference model.
module tb_rbz_spi_cmd_master;
  localparam int NDUT   = 4;
  localparam int BUDGET = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [NDUT];
  logic        valid [NDUT];
  logic [3:0]  cmd   [NDUT];
  logic [23:0] data  [NDUT];
  logic [4:0]  nbits [NDUT];
  logic        ready [NDUT];
  logic        csb   [NDUT];
  logic        sclk  [NDUT];
  logic        mosi  [NDUT];
  logic        busy  [NDUT];
  logic        done  [NDUT];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    rbz_spi_cmd_master_if u_if ();
    assign u_if.i_valid = valid[k];
    assign u_if.i_cmd   = cmd[k];
    assign u_if.i_data  = data[k];
    assign u_if.i_nbits = nbits[k];
    assign ready[k]     = u_if.o_ready;

    rbz_spi_cmd_master #(.CLK_DIV(k + 1)) u_dut (
      .i_clk     (clk),
      .i_reset_n (rst_n[k]),
      .cmd_if    (u_if.slave),
      .o_csb     (csb[k]),
      .o_sclk    (sclk[k]),
      .o_mosi    (mosi[k]),
      .o_busy    (busy[k]),
      .o_done    (done[k])
    );
  end

  int vec;
  int errs;

  // Wire monitor on the selected instance, sampled on the falling clock edge.
  int   sel;
  logic mon_clr;
  bit   bit_q [$];
  int   done_cnt, viol, low_run, high_run, low_len, high_len;
  logic p_sclk, p_mosi, p_rst;

  always @(negedge clk) begin
    if (mon_clr) begin
      bit_q.delete();
      done_cnt <= 0;
      viol     <= 0;
      low_run  <= 0;
      high_run <= 0;
      low_len  <= 0;
      high_len <= 0;
    end else if (rst_n[sel] === 1'b1 && p_rst === 1'b1) begin
      if (sclk[sel] === 1'b1 && p_sclk === 1'b0) bit_q.push_back(mosi[sel]);
      viol <= viol + int'(sclk[sel] === 1'b1 && mosi[sel] !== p_mosi)
                   + int'(csb[sel] === 1'b1 && sclk[sel] !== p_sclk);
      if (done[sel] === 1'b1) done_cnt <= done_cnt + 1;
      if (csb[sel] === 1'b0) low_run <= low_run + 1;
      else if (low_run != 0) begin low_len <= low_run; low_run <= 0; end
      if (csb[sel] === 1'b1) high_run <= high_run + 1;
      else if (high_run != 0) begin high_len <= high_run; high_run <= 0; end
    end
    p_sclk <= sclk[sel];
    p_mosi <= mosi[sel];
    p_rst  <= rst_n[sel];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model: a frame is the opcode then the top min(nbits,24) payload bits.
  function automatic int eff_n(input logic [4:0] nb);
    return (nb > 5'd24) ? 24 : int'(nb);
  endfunction

  function automatic logic [63:0] exp_bits(input logic [3:0] c, input logic [23:0] d,
                                           input logic [4:0] nb);
    logic [63:0] w;
    w = {36'd0, c, d};
    return w >> (24 - eff_n(nb));
  endfunction

  function automatic logic [63:0] got_bits();
    logic [63:0] g;
    g = 64'd0;
    foreach (bit_q[i]) g = {g[62:0], bit_q[i]};
    return g;
  endfunction

  task automatic clr_mon(input int k);
    sel     = k;
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic chk_reset_vals(input int k);
    chk("rst_csb",   64'(csb[k]),   64'd1);
    chk("rst_sclk",  64'(sclk[k]),  64'd0);
    chk("rst_mosi",  64'(mosi[k]),  64'd0);
    chk("rst_done",  64'(done[k]),  64'd0);
    chk("rst_busy",  64'(busy[k]),  64'd0);
    chk("rst_ready", 64'(ready[k]), 64'd1);
  endtask

  // Returns just after the accepting clock edge.
  task automatic offer(input int k, input logic [3:0] c, input logic [23:0] d,
                       input logic [4:0] nb, input bit hold);
    int n;
    n = 0;
    cmd[k]   = c;
    data[k]  = d;
    nbits[k] = nb;
    valid[k] = 1'b1;
    while (ready[k] !== 1'b1 && n < BUDGET) begin tick(); n++; end
    chk("offer_timeout", 64'(n < BUDGET), 64'd1);
    @(posedge clk);
    #1;
    if (!hold) valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (!(busy[k] === 1'b0 && ready[k] === 1'b1) && n < BUDGET) begin tick(); n++; end
    chk("idle_timeout", 64'(n < BUDGET), 64'd1);
    tick();
  endtask

  task automatic run_frame(input int k, input logic [3:0] c, input logic [23:0] d,
                           input logic [4:0] nb);
    int n;
    n = 4 + eff_n(nb);
    clr_mon(k);
    offer(k, c, d, nb, 1'b0);
    chk("hold_csb",   64'(csb[k]),   64'd1);
    chk("hold_ready", 64'(ready[k]), 64'd0);
    @(posedge clk);
    #1;
    chk("start_csb",  64'(csb[k]),  64'd0);
    chk("start_mosi", 64'(mosi[k]), 64'(c[3]));
    chk("start_busy", 64'(busy[k]), 64'd1);
    wait_idle(k);
    chk("frame_nbits",   64'(bit_q.size()), 64'(n));
    chk("frame_bits",    got_bits(),        exp_bits(c, d, nb));
    chk("frame_csb_low", 64'(low_len),      64'((k + 1) * (1 + 2 * n)));
    chk("frame_done",    64'(done_cnt),     64'd1);
    chk("frame_monitor", 64'(viol),         64'd0);
  endtask

  task automatic run_b2b(input int k, input logic [3:0] c1, input logic [23:0] d1,
                         input logic [4:0] n1, input logic [3:0] c2, input logic [23:0] d2,
                         input logic [4:0] n2);
    int bad, t, m1, m2;
    m1 = 4 + eff_n(n1);
    m2 = 4 + eff_n(n2);
    bad = 0;
    t = 0;
    clr_mon(k);
    offer(k, c1, d1, n1, 1'b1);
    offer(k, c2, d2, n2, 1'b0);
    chk("b2b_accept_in_frame", 64'(csb[k]), 64'd0);
    while (csb[k] === 1'b0 && t < BUDGET) begin
      if (ready[k] !== 1'b0) bad++;
      tick(); t++;
    end
    while (csb[k] === 1'b1 && t < BUDGET) begin
      if (ready[k] !== 1'b0) bad++;
      tick(); t++;
    end
    chk("b2b_timeout",      64'(t < BUDGET), 64'd1);
    chk("b2b_ready_low",    64'(bad),        64'd0);
    chk("b2b_ready_frame2", 64'(ready[k]),   64'd1);
    wait_idle(k);
    chk("b2b_csb_high", 64'(high_len),      64'(k + 2));
    chk("b2b_nbits",    64'(bit_q.size()),  64'(m1 + m2));
    chk("b2b_bits",     got_bits(),         (exp_bits(c1, d1, n1) << m2) | exp_bits(c2, d2, n2));
    chk("b2b_csb_low",  64'(low_len),       64'((k + 1) * (1 + 2 * m2)));
    chk("b2b_done",     64'(done_cnt),      64'd2);
    chk("b2b_monitor",  64'(viol),          64'd0);
  endtask

  initial begin
    int t, seen;
    vec     = 0;
    errs    = 0;
    sel     = 0;
    mon_clr = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      rst_n[k] = 1'b0;
      valid[k] = 1'b0;
      cmd[k]   = 4'd0;
      data[k]  = 24'd0;
      nbits[k] = 5'd0;
    end
    tick();
    tick();
    for (int k = 0; k < NDUT; k++) chk_reset_vals(k);
    for (int k = 0; k < NDUT; k++) rst_n[k] = 1'b1;
    tick();
    mon_clr = 1'b0;

    run_frame(1, 4'hA, 24'h5C0000, 5'd8);
    run_frame(1, 4'h3, 24'h123456, 5'd0);
    run_frame(1, 4'h5, 24'hFFFFFF, 5'd31);
    run_frame(0, 4'hC, 24'h800001, 5'd24);

    for (int k = 0; k < NDUT; k++) begin
      for (int r = 0; r < 3; r++)
        run_frame(k, 4'($urandom), 24'($urandom), 5'($urandom_range(0, 31)));
      run_b2b(k, 4'($urandom), 24'($urandom), 5'($urandom_range(0, 31)),
                 4'($urandom), 24'($urandom), 5'($urandom_range(0, 31)));
    end

    // Mid-frame reset with a second command pending in the holding register.
    clr_mon(1);
    offer(1, 4'h9, 24'hA5A5A5, 5'd16, 1'b0);
    offer(1, 4'h6, 24'h3C3C3C, 5'd12, 1'b0);
    t = 0;
    while (bit_q.size() < 5 && t < BUDGET) begin tick(); t++; end
    chk("rstmid_timeout", 64'(t < BUDGET), 64'd1);
    chk("rstmid_sclk_hi", 64'(sclk[1]),    64'd1);
    rst_n[1] = 1'b0;
    #1;
    chk_reset_vals(1);
    tick();
    rst_n[1] = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy[1] !== 1'b0 || csb[1] !== 1'b1) seen++;
    end
    chk("rstmid_pending_dropped", 64'(seen),     64'd0);
    chk("rstmid_no_done",         64'(done_cnt), 64'd0);
    run_frame(1, 4'hB, 24'hC30000, 5'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
